half_adder: RTL and testbench



---
 rtl/half_adder_pkg.sv | 19 +
 rtl/half_adder_ha_bit.sv | 20 ++
 rtl/half_adder.sv | 83 ++++++++
 tb/tb_half_adder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/half_adder_pkg.sv
// Shared constants and the single-bit result type for the half-adder slice.
package half_adder_pkg;

    localparam int unsigned DefaultWidth = 1;
    localparam int unsigned DefaultCntW  = 16;

    typedef struct packed {
        logic carry;
        logic sum;
    } ha_result_t;

    function automatic ha_result_t ha_eval(logic a, logic b);
        ha_result_t r;
        r.carry = a & b;
        r.sum   = a ^ b;
        return r;
    endfunction

endpackage

// File: rtl/half_adder_ha_bit.sv
// Purely combinational single-bit half-adder cell.
module ha_bit
    import half_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    ha_result_t res;

    always_comb begin
        res = ha_eval(a, b);
    end

    assign s = res.sum;
    assign c = res.carry;

endmodule

// File: rtl/half_adder.sv
// Registered half-adder array: WIDTH independent cells, outputs captured one cycle after in_valid.
// Optional saturating carry-event counter enabled by defining HALF_ADDER_CARRY_CNT_EN.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CNT_W = DefaultCntW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] c,
    output logic             out_valid
`ifdef HALF_ADDER_CARRY_CNT_EN
    ,
    output logic [CNT_W-1:0] carry_cnt
`endif
);

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] carry_d;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] c_q;
    logic             valid_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ha_bit u_bit (
            .a (a[i]),
            .b (b[i]),
            .s (sum_d[i]),
            .c (carry_d[i])
        );
    end

    // Data registers only load on in_valid so idle (possibly X) inputs never reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            c_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                s_q <= sum_d;
                c_q <= carry_d;
            end
        end
    end

    assign s         = s_q;
    assign c         = c_q;
    assign out_valid = valid_q;

`ifdef HALF_ADDER_CARRY_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturate at all-ones rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (in_valid && (|carry_d) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign carry_cnt = cnt_q;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Table-driven bench for half_adder: a WIDTH=1 and a WIDTH=8 instance share control inputs.
module tb_half_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       a1, b1;
    logic [7:0] a8, b8;
    logic       s1, c1, v1;
    logic [7:0] s8, c8;
    logic       v8;
`ifdef HALF_ADDER_CARRY_CNT_EN
    logic [1:0]  cnt1;
    logic [15:0] cnt8;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    half_adder #(
        .WIDTH (1),
        .CNT_W (2)
    ) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a1),
        .b         (b1),
        .s         (s1),
        .c         (c1),
        .out_valid (v1)
`ifdef HALF_ADDER_CARRY_CNT_EN
        ,
        .carry_cnt (cnt1)
`endif
    );

    half_adder #(
        .WIDTH (8),
        .CNT_W (16)
    ) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a8),
        .b         (b8),
        .s         (s8),
        .c         (c8),
        .out_valid (v8)
`ifdef HALF_ADDER_CARRY_CNT_EN
        ,
        .carry_cnt (cnt8)
`endif
    );

    typedef struct {
        logic       a1, b1;
        logic [7:0] a8, b8;
        logic       v;
        logic       es1, ec1;
        logic [7:0] es8, ec8;
        logic       ev;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic es1, input logic ec1,
                             input logic [7:0] es8, input logic [7:0] ec8, input logic ev);
        check({tag, " s1"}, {15'd0, s1}, {15'd0, es1});
        check({tag, " c1"}, {15'd0, c1}, {15'd0, ec1});
        check({tag, " v1"}, {15'd0, v1}, {15'd0, ev});
        check({tag, " s8"}, {8'd0, s8}, {8'd0, es8});
        check({tag, " c8"}, {8'd0, c8}, {8'd0, ec8});
        check({tag, " v8"}, {15'd0, v8}, {15'd0, ev});
        check({tag, " c&s"}, {8'd0, c8 & s8}, 16'd0);
    endtask

    task automatic drive(input logic v, input logic xa1, input logic xb1,
                         input logic [7:0] xa8, input logic [7:0] xb8);
        @(negedge clk);
        in_valid = v;
        a1 = xa1;
        b1 = xb1;
        a8 = xa8;
        b8 = xb8;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          a1 b1  a8     b8     v   s1 c1 s8     c8     ov
        tbl[0] = '{1'b0, 1'b0, 8'hF0, 8'h3C, 1'b1, 1'b0, 1'b0, 8'hCC, 8'h30, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 8'hAA, 8'h55, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 8'h0F, 8'h0F, 1'b1, 1'b0, 1'b1, 8'h00, 8'h0F, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h00, 8'h0F, 1'b0};
        tbl[5] = '{1'bx, 1'bx, 8'hxx, 8'hxx, 1'b0, 1'b0, 1'b1, 8'h00, 8'h0F, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 8'h81, 8'hC3, 1'b1, 1'b1, 1'b0, 8'h42, 8'h81, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h42, 8'h81, 1'b0};

        // Reset held with active inputs: outputs must stay clear.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a1 = 1'b1;
        b1 = 1'b1;
        a8 = 8'hFF;
        b8 = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_all("reset", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        end
`ifdef HALF_ADDER_CARRY_CNT_EN
        check("reset cnt", {14'd0, cnt1}, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].v, tbl[i].a1, tbl[i].b1, tbl[i].a8, tbl[i].b8);
            check_all($sformatf("vec%0d", i), tbl[i].es1, tbl[i].ec1, tbl[i].es8, tbl[i].ec8,
                      tbl[i].ev);
        end

        // Asynchronous reset between edges during valid traffic.
        drive(1'b1, 1'b1, 1'b1, 8'hFF, 8'h0F);
        check_all("pre-rst", 1'b0, 1'b1, 8'hF0, 8'h0F, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async-rst", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
`ifdef HALF_ADDER_CARRY_CNT_EN
        check("async-rst cnt", {14'd0, cnt1}, 16'd0);
`endif
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_all("post-rst", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        end

`ifdef HALF_ADDER_CARRY_CNT_EN
        // No carry: counter must not move.
        drive(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
        check("cnt nocarry", {14'd0, cnt1}, 16'd0);
        for (int i = 0; i < 5; i++) begin
            logic [1:0] exp_cnt;
            exp_cnt = (i < 3) ? 2'(i + 1) : 2'd3;
            drive(1'b1, 1'b1, 1'b1, 8'h01, 8'h01);
            check($sformatf("cnt%0d", i), {14'd0, cnt1}, {14'd0, exp_cnt});
        end
        check("cnt8", cnt8, 16'd5);
`endif

        @(negedge clk);
        in_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
